// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send,
// shifts one command byte out on device-generated clock falls and reports ACK/no-ACK/timeout.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       err_noack,
    output logic       err_timeout,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int FLT_W   = $clog2(FILTER_LEN + 1);

    localparam logic [CNT_W-1:0] INH_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] INH_START = CNT_W'(INHIBIT_CYCLES - 2);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FLT_W-1:0] FLT_LAST  = FLT_W'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_SHIFT     = 3'd2,
        S_ACK       = 3'd3,
        S_WAIT_IDLE = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

    logic             clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
    logic             filt_q, filt_d;
    logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
    logic             fall_q, fall_d;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic             noack_q, noack_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             tx_ready_q, tx_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ack_ok_q, ack_ok_d;
    logic             err_noack_q, err_noack_d;
    logic             err_timeout_q, err_timeout_d;

    // Two-flop synchronizers for both raw lines; idle-high reset avoids a false fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            data_s1_q <= 1'b1;
            data_s2_q <= 1'b1;
        end else begin
            clk_s1_q  <= ps2_clk_in;
            clk_s2_q  <= clk_s1_q;
            data_s1_q <= ps2_data_in;
            data_s2_q <= data_s1_q;
        end
    end

    // Run-length filter: output follows the clock only after FILTER_LEN differing samples.
    always_comb begin
        filt_d    = filt_q;
        flt_cnt_d = {FLT_W{1'b0}};
        if (clk_s2_q != filt_q) begin
            if (flt_cnt_q == FLT_LAST) begin
                filt_d    = clk_s2_q;
                flt_cnt_d = {FLT_W{1'b0}};
            end else begin
                flt_cnt_d = flt_cnt_q + FLT_W'(1);
            end
        end else begin
            flt_cnt_d = {FLT_W{1'b0}};
        end
    end

    assign fall_d = filt_q & ~filt_d;

    // Filter state and the registered fall strobe, aligned with filt_q going low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q    <= 1'b1;
            flt_cnt_q <= {FLT_W{1'b0}};
            fall_q    <= 1'b0;
        end else begin
            filt_q    <= filt_d;
            flt_cnt_q <= flt_cnt_d;
            fall_q    <= fall_d;
        end
    end

    // Transaction sequencing and next values of all registered outputs.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + CNT_W'(1);
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        parity_d      = parity_q;
        noack_d       = noack_q;
        clk_oe_d      = clk_oe_q;
        data_oe_d     = data_oe_q;
        tx_ready_d    = tx_ready_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        ack_ok_d      = 1'b0;
        err_noack_d   = 1'b0;
        err_timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d      = {CNT_W{1'b0}};
                clk_oe_d   = 1'b0;
                data_oe_d  = 1'b0;
                tx_ready_d = 1'b1;
                busy_d     = 1'b0;
                if (tx_valid && tx_ready_q) begin
                    state_d    = S_INHIBIT;
                    shift_d    = tx_data;
                    parity_d   = odd_parity(tx_data);
                    bit_cnt_d  = 4'd0;
                    noack_d    = 1'b0;
                    clk_oe_d   = 1'b1;
                    data_oe_d  = (INHIBIT_CYCLES == 1) ? 1'b1 : 1'b0;
                    tx_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_INHIBIT: begin
                clk_oe_d = 1'b1;
                if (cnt_q == INH_LAST) begin
                    // Release clock but keep data low: that is the start bit.
                    state_d   = S_SHIFT;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                    cnt_d     = {CNT_W{1'b0}};
                end else if (cnt_q == INH_START) begin
                    data_oe_d = 1'b1;
                end else begin
                    data_oe_d = 1'b0;
                end
            end
            S_SHIFT: begin
                clk_oe_d = 1'b0;
                if (fall_q) begin
                    cnt_d     = {CNT_W{1'b0}};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q < 4'd8) begin
                        data_oe_d = ~shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                    end else if (bit_cnt_q == 4'd8) begin
                        data_oe_d = ~parity_q;
                    end else begin
                        data_oe_d = 1'b0;
                        state_d   = S_ACK;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    state_d       = S_DONE;
                    data_oe_d     = 1'b0;
                    done_d        = 1'b1;
                    err_timeout_d = 1'b1;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_ACK: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (fall_q) begin
                    noack_d = data_s2_q;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = S_WAIT_IDLE;
                end else if (cnt_q == TMO_LAST) begin
                    state_d       = S_DONE;
                    done_d        = 1'b1;
                    err_timeout_d = 1'b1;
                end else begin
                    state_d = S_ACK;
                end
            end
            S_WAIT_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                // Expiry here is not an error; the ACK verdict already stands.
                if ((filt_q && data_s2_q) || (cnt_q == TMO_LAST)) begin
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                    ack_ok_d    = ~noack_q;
                    err_noack_d = noack_q;
                end else begin
                    state_d = S_WAIT_IDLE;
                end
            end
            S_DONE: begin
                state_d    = S_IDLE;
                cnt_d      = {CNT_W{1'b0}};
                clk_oe_d   = 1'b0;
                data_oe_d  = 1'b0;
                tx_ready_d = 1'b1;
                busy_d     = 1'b0;
            end
            default: begin
                state_d    = S_IDLE;
                cnt_d      = {CNT_W{1'b0}};
                clk_oe_d   = 1'b0;
                data_oe_d  = 1'b0;
                tx_ready_d = 1'b1;
                busy_d     = 1'b0;
            end
        endcase
    end

    // FSM state, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= {CNT_W{1'b0}};
            bit_cnt_q     <= 4'd0;
            shift_q       <= 8'h00;
            parity_q      <= 1'b0;
            noack_q       <= 1'b0;
            clk_oe_q      <= 1'b0;
            data_oe_q     <= 1'b0;
            tx_ready_q    <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            ack_ok_q      <= 1'b0;
            err_noack_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            parity_q      <= parity_d;
            noack_q       <= noack_d;
            clk_oe_q      <= clk_oe_d;
            data_oe_q     <= data_oe_d;
            tx_ready_q    <= tx_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            ack_ok_q      <= ack_ok_d;
            err_noack_q   <= err_noack_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign tx_ready    = tx_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign ack_ok      = ack_ok_q;
    assign err_noack   = err_noack_q;
    assign err_timeout = err_timeout_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a behavioural PS/2 device shares open-drain
// lines with the host; every observation is checked with an immediate assertion.
module tb_ps2_host_tx;

    localparam int INH  = 40;
    localparam int TMO  = 600;
    localparam int HALF = 30;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, busy, done, ack_ok, err_noack, err_timeout;
    logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk, dev_data;

    int tests = 0;
    int fails = 0;

    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .FILTER_LEN(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .busy(busy),
        .done(done),
        .ack_ok(ack_ok),
        .err_noack(err_noack),
        .err_timeout(err_timeout),
        .ps2_clk_in(ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Measures the clock-inhibit window; returns at the first cycle the clock is released.
    task automatic wait_request(input bit chk_len);
        int   w     = 0;
        int   n     = 0;
        logic early = 1'b0;
        logic last  = 1'b0;
        while (ps2_clk_oe !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        while (ps2_clk_oe === 1'b1 && n < 2000) begin
            early = early | last;
            last  = ps2_data_oe;
            n++;
            @(negedge clk);
        end
        if (chk_len) begin
            chk("inhibit_len", 32'(n), 32'(INH));
            chk("data_oe_early", 32'(early), 32'd0);
        end
        chk("start_on_last_inhibit", 32'(last), 32'd1);
        chk("start_held_after_release", 32'(ps2_data_oe), 32'd1);
    endtask

    task automatic dev_xfer(input int nfall, input bit do_ack, input bit ack_low,
                            input bit glitch, output logic [9:0] got);
        got = 10'd0;
        for (int i = 0; i < nfall; i++) begin
            for (int c = 0; c < HALF; c++) begin
                @(negedge clk);
                if (glitch && c == 18) dev_clk = 1'b0;
                if (glitch && c == 21) dev_clk = 1'b1;
            end
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            got[i]  = ps2_data_in;
            dev_clk = 1'b1;
        end
        if (do_ack) begin
            repeat (HALF / 2) @(negedge clk);
            dev_data = ~ack_low;
            repeat (HALF / 2) @(negedge clk);
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk  = 1'b1;
            dev_data = 1'b1;
        end
    endtask

    task automatic wait_done(input int bound, output int k);
        k = 0;
        while (done !== 1'b1 && k < bound) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", 32'(done), 32'd1);
    endtask

    // Called on the done cycle; leaves the bench on the following (idle) cycle.
    task automatic chk_status(input logic a, input logic n, input logic t);
        chk("ack_ok", 32'(ack_ok), 32'(a));
        chk("err_noack", 32'(err_noack), 32'(n));
        chk("err_timeout", 32'(err_timeout), 32'(t));
        chk("busy_at_done", 32'(busy), 32'd1);
        chk("clk_oe_at_done", 32'(ps2_clk_oe), 32'd0);
        chk("data_oe_at_done", 32'(ps2_data_oe), 32'd0);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("status_cleared", 32'({ack_ok, err_noack, err_timeout}), 32'd0);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("ready_after_done", 32'(tx_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] got;
        int         k;
        int         dones;

        rst = 1'b1; tx_data = 8'h00; tx_valid = 1'b0; dev_clk = 1'b1; dev_data = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(tx_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        chk("rst_flags", 32'({done, ack_ok, err_noack, err_timeout}), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 0xED: frame 1,0,1,1,0,1,1,1 parity 1 stop 1
        send(8'hED);
        chk("busy_on_accept", 32'(busy), 32'd1);
        wait_request(1'b1);
        dev_xfer(10, 1'b1, 1'b1, 1'b0, got);
        chk("bits_ED", 32'(got), 32'(10'b11_1110_1101));
        wait_done(200, k);
        chk_status(1'b1, 1'b0, 1'b0);

        // 0xF4 (parity 0) then 0x00 (parity 1), tx_valid held through busy
        tx_data = 8'hF4; tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'h00;
        wait_request(1'b1);
        dev_xfer(10, 1'b1, 1'b1, 1'b0, got);
        chk("bits_F4", 32'(got), 32'(10'b10_1111_0100));
        wait_done(200, k);
        chk_status(1'b1, 1'b0, 1'b0);
        chk("b2b_not_started_in_idle", 32'(ps2_clk_oe), 32'd0);
        @(negedge clk);
        tx_valid = 1'b0;
        chk("b2b_accepted", 32'(busy), 32'd1);
        wait_request(1'b1);
        dev_xfer(10, 1'b1, 1'b1, 1'b0, got);
        chk("bits_00", 32'(got), 32'(10'b11_0000_0000));
        wait_done(200, k);
        chk_status(1'b1, 1'b0, 1'b0);

        // 0xAA with a tx_valid pulse during inhibit; device withholds ACK
        send(8'hAA);
        repeat (5) @(negedge clk);
        chk("ready_low_in_inhibit", 32'(tx_ready), 32'd0);
        tx_data = 8'h55; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_request(1'b0);
        dev_xfer(10, 1'b1, 1'b0, 1'b0, got);
        chk("bits_AA", 32'(got), 32'(10'b11_1010_1010));
        wait_done(200, k);
        chk_status(1'b0, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        chk("inhibit_pulse_not_queued", 32'({busy, ps2_clk_oe}), 32'd0);

        // Reset asserted mid-shift while data is being driven low
        send(8'h3C);
        wait_request(1'b1);
        dev_xfer(2, 1'b0, 1'b0, 1'b0, got);
        chk("bits_3C_partial", 32'(got), 32'd0);
        chk("data_oe_before_rst", 32'(ps2_data_oe), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        chk("rst_async_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        dones = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        chk("no_done_after_rst", 32'(dones), 32'd0);
        chk("ready_after_rst", 32'(tx_ready), 32'd1);

        // 0x5A with 3-cycle clock glitches in every high phase
        send(8'h5A);
        wait_request(1'b1);
        dev_xfer(10, 1'b1, 1'b1, 1'b1, got);
        chk("bits_5A_glitch", 32'(got), 32'(10'b11_0101_1010));
        wait_done(200, k);
        chk_status(1'b1, 1'b0, 1'b0);

        // Device never clocks: timeout exactly TMO cycles after release
        send(8'h12);
        wait_request(1'b1);
        wait_done(2000, k);
        chk("timeout_no_clock_cycles", 32'(k), 32'(TMO));
        chk_status(1'b0, 1'b0, 1'b1);

        // Device stops after fall 5 (clock left low)
        send(8'h81);
        wait_request(1'b1);
        dev_xfer(4, 1'b0, 1'b0, 1'b0, got);
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("timeout_after_fall5_window", 32'((k >= TMO + 5) && (k <= TMO + 20)), 32'd1);
        chk_status(1'b0, 1'b0, 1'b1);
        dev_clk = 1'b1;
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
